// File: rtl/seq_compare_subtractor.sv
// Multi-cycle slice subtractor feeding the EX-stage comparator.
// Produces S = A - B plus the true sign NEG and ZERO flag.
module seq_compare_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SIGNED,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             NEG,
  output logic             ZERO
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_q, b_q, s_n;
  logic             sgn_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [CHUNK:0]   sum;
  logic             last, accept, ovf, neg_n;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_n = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (last) state_n = FIN;
      end
      FIN: begin
        if (START) begin
          state_n = RUN;
          accept  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign last = (idx == IW'(N - 1));

  // A + ~B + carry, one slice at a time; carry starts at 1
  always_comb begin
    sum = {1'b0, a_q[idx*CHUNK +: CHUNK]}
        + {1'b0, ~b_q[idx*CHUNK +: CHUNK]}
        + {{CHUNK{1'b0}}, carry};
    s_n = S;
    s_n[idx*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  assign ovf   = (a_q[WIDTH-1] ^ b_q[WIDTH-1])
               & (s_n[WIDTH-1] ^ a_q[WIDTH-1]);
  assign neg_n = sgn_q ? (s_n[WIDTH-1] ^ ovf)
                       : ~sum[CHUNK];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      idx   <= '0;
      carry <= 1'b1;
      S     <= '0;
      NEG   <= 1'b0;
      ZERO  <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      sgn_q <= SIGNED;
      idx   <= '0;
      carry <= 1'b1;
      S     <= '0;
    end else if (state == RUN) begin
      S     <= s_n;
      carry <= sum[CHUNK];
      if (last) begin
        idx  <= '0;
        NEG  <= neg_n;
        ZERO <= (s_n == '0);
      end else begin
        idx  <= idx + 1'b1;
      end
    end
  end

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);

endmodule

// File: tb/tb_seq_compare_subtractor.sv
// Scoreboard bench for seq_compare_subtractor.
// Expected results come from plain arithmetic on the operands.
module tb_seq_compare_subtractor;

  localparam int W = 32;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         SIGNED = 1'b0;
  logic         BUSY, DONE, NEG, ZERO;
  logic [W-1:0] S;

  seq_compare_subtractor #(.WIDTH(W), .CHUNK(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .A(A), .B(B), .SIGNED(SIGNED),
    .BUSY(BUSY), .DONE(DONE), .S(S),
    .NEG(NEG), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] s;
    logic         neg;
    logic         zero;
    int           edge_no;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc++;

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic sg, int e);
    exp_t m;
    m.s       = a - b;
    m.neg     = sg ? ($signed(a) < $signed(b)) : (a < b);
    m.zero    = (a == b);
    m.edge_no = e;
    return m;
  endfunction

  task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // monitor: compare every DONE pulse against the head of the queue
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done got 1 want 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("s", S, e.s);
        chk("neg", W'(NEG), W'(e.neg));
        chk("zero", W'(ZERO), W'(e.zero));
        chk("latency", W'(cyc), W'(e.edge_no + N));
        chk("busy_at_done", W'(BUSY), '0);
      end
    end
  end

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic sg,
                       bit push);
    @(negedge CLK);
    A = a;
    B = b;
    SIGNED = sg;
    START = 1'b1;
    if (push) q.push_back(model(a, b, sg, cyc + 1));
    @(negedge CLK);
    START = 1'b0;
    A = $urandom;
    B = $urandom;
    SIGNED = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got %0d pending want 0", q.size());
      q.delete();
    end
    @(negedge CLK);
  endtask

  task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, logic sg);
    issue(a, b, sg, 1'b1);
    drain();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_s"}, S, '0);
    chk({tag, "_neg"}, W'(NEG), '0);
    chk({tag, "_zero"}, W'(ZERO), '0);
    chk({tag, "_busy"}, W'(BUSY), '0);
    chk({tag, "_done"}, W'(DONE), '0);
  endtask

  logic [W-1:0] ra, rb;

  initial begin
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check_reset_outputs("reset");

    run_op(32'd5, 32'd3, 1'b0);
    run_op(32'd3, 32'd5, 1'b0);
    run_op(32'd3, 32'd5, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1);
    run_op(32'h8000_0000, 32'd1, 1'b1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h1234_ABCD, 32'h1234_ABCD, 1'b0);
    run_op(32'h1234_ABCD, 32'h1234_ABCD, 1'b1);
    run_op(32'd0, 32'hFFFF_FFFF, 1'b0);

    // START during RUN with new operands is ignored
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    @(negedge CLK);
    A = 32'hDEAD_BEEF;
    B = 32'h1;
    SIGNED = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    drain();

    // START held high: back-to-back acceptance every N+1 cycles
    @(negedge CLK);
    START = 1'b1;
    for (int j = 0; j < 4; j++) begin
      ra = $urandom;
      rb = (j == 2) ? ra : $urandom;
      A = ra;
      B = rb;
      SIGNED = 1'(j);
      q.push_back(model(ra, rb, 1'(j), cyc + 1));
      repeat (N + 1) @(negedge CLK);
    end
    START = 1'b0;
    drain();

    // reset in the middle of an op aborts it
    issue(32'h0000_1000, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_outputs("abort");
    RESET = 1'b0;
    repeat (8) @(negedge CLK);
    run_op(32'h0000_1000, 32'h0000_0001, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 1) ra = 32'h8000_0000;
      if (i % 8 == 3) rb = 32'h7FFF_FFFF;
      if (i % 8 == 5) rb = ra;
      if (i % 8 == 6) rb = ra ^ 32'h8000_0000;
      run_op(ra, rb, 1'($urandom));
    end

    chk("queue_empty", W'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
